// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin/fixed-priority system bus arbiter:
// state encodings, grant/free polarities, arbitration modes, default burst sizes.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } arb_state_t;

   localparam logic GRANT_ENABLE  = 1'b1;
   localparam logic GRANT_DISABLE = 1'b0;
   localparam logic FREE_ENABLE   = 1'b1;

   localparam logic ARB_MODE_FIXED = 1'b0;
   localparam logic ARB_MODE_RR    = 1'b1;

   // Default burst lengths in words for the legacy masters.
   localparam logic [7:0] WORDS_IO      = 8'd1;
   localparam logic [7:0] WORDS_L2CACHE = 8'd8;
   localparam logic [7:0] WORDS_UNCACHE = 8'd4;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational winner picker: lowest asserted request at or after a start
// index, searched cyclically; fixed-priority mode always starts at index 0.
module rr_pick
   import bus_arbiter_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   input  logic             i_mode,
   output logic             o_valid,
   output logic [IDX_W-1:0] o_winner
);

   always_comb begin
      int start;
      int idx;
      o_valid  = 1'b0;
      o_winner = '0;
      start    = (i_mode == ARB_MODE_RR) ? int'(i_ptr) : 0;
      idx      = 0;
      // Scan from the farthest offset down so the nearest hit is written last.
      for (int k = N - 1; k >= 0; k--) begin
         idx = start + k;
         if (idx >= N) idx = idx - N;
         if (i_req[idx]) begin
            o_valid  = 1'b1;
            o_winner = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_rr.sv
// System bus arbiter for NUM_MASTERS requesters with runtime fixed/round-robin
// selection, owner-only release, a turnaround gap and a tenure watchdog.
module bus_arbiter_rr
   import bus_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int WORD_W      = 8,
   parameter int TIMEOUT     = 1024,
   parameter int ID_W        = 3
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [NUM_MASTERS-1:0]        req,
   input  logic [NUM_MASTERS-1:0]        free,
   input  logic                          rr_mode,
   input  logic [NUM_MASTERS*WORD_W-1:0] word_cfg,
   output logic [NUM_MASTERS-1:0]        grant,
   output logic [ID_W-1:0]               grant_id,
   output logic [WORD_W-1:0]             word_number,
   output logic                          busy,
   output logic                          timeout_err,
   output arb_state_t                    dbg_state
);

   // Watchdog only needs to reach TIMEOUT-1; with TIMEOUT=0 it free-runs unused.
   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   arb_state_t             r_state, w_state_nxt;
   logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
   logic [ID_W-1:0]        r_grant_id, w_grant_id_nxt;
   logic [WORD_W-1:0]      r_words, w_words_nxt;
   logic                   r_busy, w_busy_nxt;
   logic                   r_tmo, w_tmo_nxt;
   logic [ID_W-1:0]        r_ptr, w_ptr_nxt;
   logic [WD_W-1:0]        r_wdog, w_wdog_nxt;

   logic                   w_pick_valid;
   logic [ID_W-1:0]        w_winner;
   logic [WORD_W-1:0]      w_cfg_sel;
   logic                   w_free_hit;
   logic                   w_wdog_expired;

   rr_pick #(
      .N     (NUM_MASTERS),
      .IDX_W (ID_W)
   ) u_pick (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .i_mode   (rr_mode),
      .o_valid  (w_pick_valid),
      .o_winner (w_winner)
   );

   assign w_cfg_sel      = word_cfg[int'(w_winner)*WORD_W +: WORD_W];
   // grant is one-hot, so masking free with it selects the owner's release only.
   assign w_free_hit     = ((|(free & r_grant)) == FREE_ENABLE);
   assign w_wdog_expired = (TIMEOUT != 0) && (r_wdog == WD_LAST);

   always_comb begin
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant;
      w_grant_id_nxt = r_grant_id;
      w_words_nxt    = r_words;
      w_busy_nxt     = r_busy;
      w_tmo_nxt      = 1'b0;
      w_ptr_nxt      = r_ptr;
      w_wdog_nxt     = r_wdog;
      unique case (r_state)
         ST_IDLE: begin
            w_grant_nxt    = {NUM_MASTERS{GRANT_DISABLE}};
            w_grant_id_nxt = '0;
            w_busy_nxt     = 1'b0;
            if (w_pick_valid) begin
               w_state_nxt    = ST_BUSY;
               w_grant_nxt    = {{(NUM_MASTERS-1){GRANT_DISABLE}}, GRANT_ENABLE} << w_winner;
               w_grant_id_nxt = w_winner;
               w_words_nxt    = w_cfg_sel;
               w_busy_nxt     = 1'b1;
               w_wdog_nxt     = '0;
               w_ptr_nxt      = (w_winner == ID_W'(NUM_MASTERS - 1)) ? '0 : w_winner + 1'b1;
            end
         end
         ST_BUSY: begin
            w_wdog_nxt = r_wdog + 1'b1;
            if (w_free_hit || w_wdog_expired) begin
               w_state_nxt    = ST_GAP;
               w_grant_nxt    = {NUM_MASTERS{GRANT_DISABLE}};
               w_grant_id_nxt = '0;
               w_busy_nxt     = 1'b0;
               w_tmo_nxt      = !w_free_hit;
            end
         end
         ST_GAP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt    = ST_IDLE;
            w_grant_nxt    = {NUM_MASTERS{GRANT_DISABLE}};
            w_grant_id_nxt = '0;
            w_busy_nxt     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= ST_IDLE;
         r_grant    <= '0;
         r_grant_id <= '0;
         r_words    <= '0;
         r_busy     <= 1'b0;
         r_tmo      <= 1'b0;
         r_ptr      <= '0;
         r_wdog     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_grant_id <= w_grant_id_nxt;
         r_words    <= w_words_nxt;
         r_busy     <= w_busy_nxt;
         r_tmo      <= w_tmo_nxt;
         r_ptr      <= w_ptr_nxt;
         r_wdog     <= w_wdog_nxt;
      end
   end

   assign grant       = r_grant;
   assign grant_id    = r_grant_id;
   assign word_number = r_words;
   assign busy        = r_busy;
   assign timeout_err = r_tmo;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios plus random traffic, every cycle
// compared with a tenure-level reference model of the arbitration rules.
module tb_bus_arbiter_rr;
   import bus_arbiter_pkg::*;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int TO  = 16;
   localparam int IDW = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]   req = '0;
   logic [N-1:0]   free = '0;
   logic           rr_mode = 1'b0;
   logic [N*W-1:0] word_cfg = '0;
   logic [N-1:0]   grant;
   logic [IDW-1:0] grant_id;
   logic [W-1:0]   word_number;
   logic           busy;
   logic           timeout_err;
   arb_state_t     dbg_state;

   bus_arbiter_rr #(
      .NUM_MASTERS (N),
      .WORD_W      (W),
      .TIMEOUT     (TO),
      .ID_W        (IDW)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .req         (req),
      .free        (free),
      .rr_mode     (rr_mode),
      .word_cfg    (word_cfg),
      .grant       (grant),
      .grant_id    (grant_id),
      .word_number (word_number),
      .busy        (busy),
      .timeout_err (timeout_err),
      .dbg_state   (dbg_state)
   );

   // ---------------- reference model ----------------
   logic [W-1:0] cfg [N];
   int           m_owner = -1;  // granted master, -1 when nobody owns the bus
   int           m_age   = 0;   // cycles since the grant edge
   bit           m_gap   = 0;   // turnaround cycle pending
   int           m_ptr   = 0;
   logic [W-1:0] m_words = '0;
   bit           m_tmo   = 0;

   logic [IDW-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   task automatic model_reset();
      m_owner = -1; m_age = 0; m_gap = 0; m_ptr = 0; m_words = '0; m_tmo = 0;
   endtask

   task automatic model_step();
      m_tmo = 0;
      if (m_owner >= 0) begin
         if (free[m_owner]) begin
            m_owner = -1; m_gap = 1;
         end else if (TO != 0 && m_age == TO - 1) begin
            m_owner = -1; m_gap = 1; m_tmo = 1;
         end else begin
            m_age++;
         end
      end else if (m_gap) begin
         m_gap = 0;
      end else if (req != '0) begin
         int start;
         start = rr_mode ? m_ptr : 0;
         for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) begin
               m_owner = (start + k) % N;
               break;
            end
         end
         m_age   = 0;
         m_words = cfg[m_owner];
         m_ptr   = (m_owner + 1) % N;
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check("grant",       32'(grant),       (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
      check("grant_id",    32'(grant_id),    (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      check("busy",        32'(busy),        32'(m_owner >= 0));
      check("word_number", 32'(word_number), 32'(m_words));
      check("timeout_err", 32'(timeout_err), 32'(m_tmo));
      check("dbg_gap",     32'(dbg_state == ST_GAP), 32'(m_gap));
   endtask

   // ---------------- drivers ----------------
   task automatic set_cfg(input int i, input logic [W-1:0] v);
      cfg[i] = v;
      word_cfg[i*W +: W] = v;
   endtask

   task automatic step();
      @(posedge clk);
      if (resetn) model_step();
      #1;
      check_outputs();
   endtask

   task automatic drain();
      req = '0;
      for (int c = 0; c < 60 && (m_owner >= 0 || m_gap); c++) begin
         free = (m_owner >= 0) ? N'(1 << m_owner) : '0;
         step();
      end
      free = '0;
      check("drain_idle", 32'(busy), 32'd0);
   endtask

   task automatic reset_pulse();
      #2 resetn = 1'b0;
      #1;
      model_reset();
      check_outputs();
      step();
      @(negedge clk);
      resetn = 1'b1;
   endtask

   // Runs until n grants rise; each owner frees at the start of its hold-th cycle.
   task automatic run_tenures(input int n, input int hold);
      int  got, low;
      bit  pb, seen_fall;
      got = 0; low = 0; pb = busy; seen_fall = 0;
      for (int c = 0; c < 400 && got < n; c++) begin
         step();
         if (busy && !pb) begin
            got++;
            if (exp_q.size() > 0) check("grant_id_seq", 32'(grant_id), 32'(exp_q.pop_front()));
            if (seen_fall) check("gap_len", 32'(low), 32'd2);
         end
         if (!busy && pb) begin
            seen_fall = 1; low = 0;
         end
         if (!busy) low++;
         pb = busy;
         free = (m_owner >= 0 && m_age == hold - 1) ? N'(1 << m_owner) : '0;
      end
      free = '0;
      check("tenure_count", 32'(got), 32'(n));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      int c;
      set_cfg(0, WORDS_IO);
      set_cfg(1, WORDS_L2CACHE);
      set_cfg(2, WORDS_UNCACHE);
      set_cfg(3, 8'd2);
      model_reset();
      repeat (3) @(posedge clk);
      #1 check_outputs();
      @(negedge clk);
      resetn = 1'b1;
      step();

      // round-robin rotation from a fresh pointer
      rr_mode = 1'b1;
      req = 4'b1111;
      exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
      run_tenures(5, 3);
      drain();

      // fixed priority with 1-cycle request-to-grant latency
      rr_mode = 1'b0;
      req = 4'b1110;
      step();
      check("fp_latency", 32'(busy), 32'd1);
      check("fp_words", 32'(word_number), 32'd8);
      exp_q = '{3'd1, 3'd1};
      run_tenures(2, 3);
      drain();

      // a free from a non-owner is ignored
      req = 4'b0100;
      step();
      req = '0;
      free = 4'b0001;
      step();
      check("foreign_free_grant", 32'(grant), 32'b0100);
      free = '0;
      step();
      free = 4'b0100;
      step();
      check("own_free_grant", 32'(grant), 32'd0);
      free = '0;
      drain();

      // watchdog release exactly TO cycles after the grant edge
      req = 4'b1000;
      step();
      req = '0;
      for (c = 1; c <= 40; c++) begin
         step();
         if (!busy) break;
      end
      check("wdog_cycles", 32'(c), 32'(TO));
      check("wdog_err", 32'(timeout_err), 32'd1);
      step();
      check("wdog_err_pulse", 32'(timeout_err), 32'd0);
      drain();

      // free in the same cycle as expiry wins, no error pulse
      req = 4'b1000;
      step();
      req = '0;
      for (int k = 0; k < 40 && m_age != TO - 1; k++) step();
      check("wdog_reach", 32'(m_age), 32'(TO - 1));
      free = 4'b1000;
      step();
      free = '0;
      check("free_beats_wdog_err", 32'(timeout_err), 32'd0);
      check("free_beats_wdog_busy", 32'(busy), 32'd0);
      drain();

      // word_cfg is sampled only at the grant edge
      set_cfg(0, 8'd8);
      req = 4'b0001;
      step();
      check("cfg_latch", 32'(word_number), 32'd8);
      set_cfg(0, 8'd16);
      req = '0;
      repeat (3) step();
      check("cfg_hold", 32'(word_number), 32'd8);
      free = 4'b0001;
      step();
      free = '0;
      req = 4'b0001;
      step();
      step();
      check("cfg_new", 32'(word_number), 32'd16);
      drain();

      // asynchronous reset in the middle of a tenure
      rr_mode = 1'b1;
      req = 4'b0100;
      step();
      #2 resetn = 1'b0;
      #1;
      check("rst_async_grant", 32'(grant), 32'd0);
      check("rst_async_busy", 32'(busy), 32'd0);
      check("rst_async_id", 32'(grant_id), 32'd0);
      check("rst_async_words", 32'(word_number), 32'd0);
      model_reset();
      step();
      step();
      @(negedge clk);
      resetn = 1'b1;
      req = 4'b1000;
      step();
      check("rst_rr_id", 32'(grant_id), 32'd3);
      drain();

      // random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) rr_mode = ~rr_mode;
         if ($urandom_range(0, 9) == 0) set_cfg($urandom_range(0, N - 1), W'($urandom_range(0, 255)));
         free = N'($urandom_range(0, 15));
         if (m_owner >= 0) begin
            if ($urandom_range(0, 5) == 0) free[m_owner] = 1'b1;
            else free[m_owner] = 1'b0;
         end
         if ($urandom_range(0, 799) == 0) reset_pulse();
         else step();
      end
      free = '0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Parametrised successor to the three-master fixed-priority bus arbiter; it arbitrates NUM_MASTERS requesters (IO, L2cache, uncache and future DMA) onto the single system bus.
- Runtime-selectable arbitration: fixed priority (index 0 highest) or round-robin.
- Only the granted master's free signal ends a tenure; a watchdog revokes a grant that is never freed.
- Per-master burst word count is registered with the grant and forwarded to the UART/bus controller.

Parameters:
NUM_MASTERS, 4, number of requesters (2..8).
WORD_W, 8, width of word_number and each per-master word-count field.
TIMEOUT, 1024, cycles a grant may be held before forced release; 0 disables the watchdog.
ID_W, 3, width of grant_id; must satisfy 2**ID_W >= NUM_MASTERS.

Ports:
clk  in  1  system clock, rising edge.
resetn  in  1  reset, asynchronous assert, active-low (synchronously released upstream).
req  in  NUM_MASTERS  per-master bus request, level.
free  in  NUM_MASTERS  per-master release, single-cycle pulse or level.
rr_mode  in  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE.
word_cfg  in  NUM_MASTERS*WORD_W  per-master burst word count; field i is bits [i*WORD_W +: WORD_W].
grant  out  NUM_MASTERS  one-hot grant, registered.
grant_id  out  ID_W  binary index of the granted master; valid while busy=1.
word_number  out  WORD_W  word count latched at grant time.
busy  out  1  bus owned (state BUSY).
timeout_err  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, grant=0, grant_id=0, word_number=0, busy=0, timeout_err=0, rr_ptr=0, wdog=0.
- States: IDLE, BUSY, GAP.
- IDLE:
  - req==0: hold all outputs at 0 except word_number, which keeps its last value.
  - req!=0: compute winner combinationally. On the next edge: grant=onehot(winner), grant_id=winner, word_number=word_cfg[winner], busy=1, wdog=0, state=BUSY. Latency is request to grant in 1 cycle.
- Winner selection:
  - rr_mode=0: lowest asserted index wins.
  - rr_mode=1: first asserted index at or above rr_ptr, searching cyclically with wrap from NUM_MASTERS-1 to 0.
  - On every grant, in either mode, rr_ptr = winner+1 mod NUM_MASTERS.
- BUSY:
  - wdog increments each cycle.
  - free[grant_id]=1: on the next edge grant=0, busy=0, state=GAP.
  - free on any other index is ignored.
  - TIMEOUT!=0 and wdog==TIMEOUT-1 with no valid free: grant=0, busy=0, timeout_err=1 for one cycle, state=GAP.
  - Valid free and timeout in the same cycle: free wins and timeout_err stays 0.
  - Changes to req while in BUSY are ignored.
- GAP: one mandatory dead cycle with all grants 0 (bus turnaround); then state=IDLE. The earliest regrant is 2 cycles after the release edge.
- grant is always one-hot or zero; it never has two bits set.
- word_cfg is sampled only at the grant edge; later changes do not affect word_number.
- rr_mode changes during BUSY take effect at the next arbitration.
- Reset asserted mid-tenure: all outputs reach their reset values immediately, with no GAP cycle.

Decomposition:
- Shared package bus_arbiter_pkg:
  - state encodings IDLE/BUSY/GAP;
  - GRANT_ENABLE/DISABLE and FREE_ENABLE constants;
  - ARB_MODE_FIXED/ARB_MODE_RR;
  - default per-master word counts (IO, L2CACHE, UNCACHE).
- Sub-module rr_pick: combinational picker. Inputs req, ptr, mode; outputs valid, winner index.

Test Plan:
- Fixed priority, simultaneous requests: rr_mode=0, req=4'b1110 held continuously -> grants go to 1, 1, 1… (index 1 each tenure); word_number=word_cfg[1]; grant appears 1 cycle after req.
- Round-robin rotation: rr_mode=1, req=4'b1111 held, each master frees 3 cycles into its tenure -> grant_id sequence 0,1,2,3,0 with exactly one GAP cycle between grants.
- Foreign free ignored: master 2 granted, free=4'b0001 pulsed -> grant stays 4'b0100; then free=4'b0100 -> grant=0 next cycle.
- Watchdog: TIMEOUT=16, master 3 granted, never frees -> grant drops exactly 16 cycles after the grant edge, timeout_err is high for 1 cycle; test also that free and timeout in the same cycle give no error pulse.
- Reset mid-tenure: resetn low during BUSY -> grant, busy, grant_id, word_number all 0 asynchronously; after release, req=4'b1000 in rr_mode=1 -> grant_id=3 (rr_ptr reset to 0, first asserted index searched from 0).
- word_cfg stability: change word_cfg[0] from 8 to 16 during master 0's tenure -> word_number stays 8 until the next grant.
